// File: rtl/coeff_token_prefix_fsm.sv
// Purpose : serial parser for one H.264 coeff_token code. It counts leading zeros up to the
//           terminating 1, captures 0..3 suffix bits, and reports the prefix length, the suffix
//           value and the total code length to the LUT stage.
// Latency : two cycles from Start to TokenValid for the code "1" with no suffix; each further
//           code bit adds one cycle.
// Backpressure: bit_ready_o is high only while parsing. Cycles with bit_valid_i low hold all
//           state. In OUT the results stay stable until token_ready_i is seen.
// Ports   : clk_i, rst_n_i (async, active-low); start_i; bit_in_i/bit_valid_i/bit_ready_o
//           serial input; suffix_len_i from the LUT; leading_zeros_o, suffix_o, code_len_o,
//           token_valid_o/token_ready_i result handshake; error_o when the prefix is too long.
// Option  : defining COEFF_TOKEN_BITCOUNT_EN adds bit_count_o[15:0], a free-running count of
//           accepted bits. Start does not clear it.
module coeff_token_prefix_fsm #(
  parameter int unsigned MAX_LZ = 14
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       bit_in_i,
  input  logic       bit_valid_i,
  output logic       bit_ready_o,
  input  logic [1:0] suffix_len_i,
  output logic [3:0] leading_zeros_o,
  output logic [2:0] suffix_o,
  output logic [4:0] code_len_o,
  output logic       token_valid_o,
  input  logic       token_ready_i,
  output logic       error_o
`ifdef COEFF_TOKEN_BITCOUNT_EN
  ,
  output logic [15:0] bit_count_o
`endif
);

  localparam logic [3:0] MaxLz = 4'(MAX_LZ);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PREFIX = 3'd1,
    S_SUFFIX = 3'd2,
    S_OUT    = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] lz_q, lz_d;
  logic [2:0] sfx_q, sfx_d;
  logic [4:0] cl_q, cl_d;
  logic [1:0] slen_q, slen_d;   // suffix length latched on the terminating 1
  logic [1:0] scnt_q, scnt_d;   // suffix bits taken so far
  logic       err_q, err_d;
  logic       accept;
  logic [1:0] scnt_inc;

  assign bit_ready_o     = (state_q == S_PREFIX) || (state_q == S_SUFFIX);
  assign accept          = bit_valid_i && bit_ready_o;
  assign token_valid_o   = (state_q == S_OUT);
  assign leading_zeros_o = lz_q;
  assign suffix_o        = sfx_q;
  assign code_len_o      = cl_q;
  assign error_o         = err_q;
  assign scnt_inc        = scnt_q + 2'd1;

  always_comb begin
    state_d = state_q;
    lz_d    = lz_q;
    sfx_d   = sfx_q;
    cl_d    = cl_q;
    slen_d  = slen_q;
    scnt_d  = scnt_q;
    err_d   = err_q;
    unique case (state_q)
      // The outputs of the previous token stay visible in IDLE until the next Start.
      S_IDLE, S_ERR: begin
        if (start_i) begin
          lz_d    = 4'd0;
          sfx_d   = 3'd0;
          cl_d    = 5'd0;
          scnt_d  = 2'd0;
          err_d   = 1'b0;
          state_d = S_PREFIX;
        end
      end
      S_PREFIX: begin
        if (accept) begin
          if (bit_in_i) begin
            // suffix_len_i is looked up from lz_q in this cycle, so it is sampled only here.
            slen_d  = suffix_len_i;
            scnt_d  = 2'd0;
            cl_d    = {1'b0, lz_q} + 5'd1 + {3'b000, suffix_len_i};
            state_d = (suffix_len_i != 2'd0) ? S_SUFFIX : S_OUT;
          end else if (lz_q == MaxLz) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else begin
            lz_d = lz_q + 4'd1;
          end
        end
      end
      S_SUFFIX: begin
        if (accept) begin
          sfx_d  = {sfx_q[1:0], bit_in_i};
          scnt_d = scnt_inc;
          if (scnt_inc == slen_q) begin
            state_d = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (token_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      lz_q    <= 4'd0;
      sfx_q   <= 3'd0;
      cl_q    <= 5'd0;
      slen_q  <= 2'd0;
      scnt_q  <= 2'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lz_q    <= lz_d;
      sfx_q   <= sfx_d;
      cl_q    <= cl_d;
      slen_q  <= slen_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
    end
  end

`ifdef COEFF_TOKEN_BITCOUNT_EN
  logic [15:0] bit_count_q;

  // The counter wraps naturally from 0xFFFF to 0x0000.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bit_count_q <= 16'd0;
    end else if (accept) begin
      bit_count_q <= bit_count_q + 16'd1;
    end
  end

  assign bit_count_o = bit_count_q;
`endif

endmodule

// File: tb/tb_coeff_token_prefix_fsm.sv
module tb_coeff_token_prefix_fsm;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i;
  logic       bit_in_i;
  logic       bit_valid_i;
  logic       bit_ready_o;
  logic [1:0] suffix_len_i;
  logic [3:0] leading_zeros_o;
  logic [2:0] suffix_o;
  logic [4:0] code_len_o;
  logic       token_valid_o;
  logic       token_ready_i;
  logic       error_o;
`ifdef COEFF_TOKEN_BITCOUNT_EN
  logic [15:0] bit_count_o;
`endif

  always #5 clk_i = ~clk_i;

  coeff_token_prefix_fsm #(.MAX_LZ(14)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .start_i        (start_i),
    .bit_in_i       (bit_in_i),
    .bit_valid_i    (bit_valid_i),
    .bit_ready_o    (bit_ready_o),
    .suffix_len_i   (suffix_len_i),
    .leading_zeros_o(leading_zeros_o),
    .suffix_o       (suffix_o),
    .code_len_o     (code_len_o),
    .token_valid_o  (token_valid_o),
    .token_ready_i  (token_ready_i),
    .error_o        (error_o)
`ifdef COEFF_TOKEN_BITCOUNT_EN
    ,
    .bit_count_o    (bit_count_o)
`endif
  );

  // Each row gives the inputs applied in one cycle and the outputs expected in that same
  // cycle, before the clock edge that acts on those inputs.
  typedef struct {
    logic       start;
    logic       bin;
    logic       bvld;
    logic [1:0] slen;
    logic       trdy;
    logic       e_rdy;
    logic       e_tv;
    logic       e_err;
    logic [3:0] e_lz;
    logic [2:0] e_sfx;
    logic [4:0] e_cl;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void add(logic st, logic b, logic v, logic [1:0] sl, logic tr,
                              logic rdy, logic tv, logic err,
                              logic [3:0] lz, logic [2:0] sfx, logic [4:0] cl);
    vec_t r;
    r.start = st;  r.bin = b;   r.bvld = v;  r.slen = sl;  r.trdy = tr;
    r.e_rdy = rdy; r.e_tv = tv; r.e_err = err;
    r.e_lz = lz;   r.e_sfx = sfx; r.e_cl = cl;
    vecs.push_back(r);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic rdy, input logic tv, input logic err,
                         input logic [3:0] lz, input logic [2:0] sfx, input logic [4:0] cl);
    chk({tag, " bit_ready"}, 16'(bit_ready_o), 16'(rdy));
    chk({tag, " token_valid"}, 16'(token_valid_o), 16'(tv));
    chk({tag, " error"}, 16'(error_o), 16'(err));
    chk({tag, " leading_zeros"}, 16'(leading_zeros_o), 16'(lz));
    chk({tag, " suffix"}, 16'(suffix_o), 16'(sfx));
    chk({tag, " code_len"}, 16'(code_len_o), 16'(cl));
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic st, input logic b, input logic v, input logic [1:0] sl,
                       input logic tr);
    start_i = st; bit_in_i = b; bit_valid_i = v; suffix_len_i = sl; token_ready_i = tr;
  endtask

`ifdef COEFF_TOKEN_BITCOUNT_EN
  // Feed zeros while the parser is in PREFIX.
  task automatic feed_zeros(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
      step();
    end
  endtask
`endif

  initial begin
    // Code "1", no suffix, token_ready already high: TokenValid in cycle 2.
    add(1,0,0,0,0, 0,0,0, 0,0,0);
    add(0,1,1,0,1, 1,0,0, 0,0,0);
    add(0,0,0,0,1, 0,1,0, 0,0,1);
    add(0,0,0,0,0, 0,0,0, 0,0,1);
    // 0001 101, suffix_len 3; a Start inside PREFIX is ignored.
    add(1,0,0,0,0, 0,0,0, 0,0,1);
    add(0,0,1,0,0, 1,0,0, 0,0,0);
    add(1,0,1,0,0, 1,0,0, 1,0,0);
    add(0,0,1,0,0, 1,0,0, 2,0,0);
    add(0,1,1,3,0, 1,0,0, 3,0,0);
    add(0,1,1,0,0, 1,0,0, 3,0,7);
    add(0,0,1,2,0, 1,0,0, 3,1,7);
    add(0,1,1,1,0, 1,0,0, 3,2,7);
    add(0,0,0,0,1, 0,1,0, 3,5,7);
    add(0,0,0,0,0, 0,0,0, 3,5,7);
    // The same code with two stall cycles mid-suffix and token_ready low for three cycles.
    add(1,0,0,0,0, 0,0,0, 3,5,7);
    add(0,0,1,0,0, 1,0,0, 0,0,0);
    add(0,0,1,0,0, 1,0,0, 1,0,0);
    add(0,0,1,0,0, 1,0,0, 2,0,0);
    add(0,1,1,3,0, 1,0,0, 3,0,0);
    add(0,1,1,0,0, 1,0,0, 3,0,7);
    add(0,1,0,0,0, 1,0,0, 3,1,7);
    add(0,0,0,0,0, 1,0,0, 3,1,7);
    add(0,0,1,0,0, 1,0,0, 3,1,7);
    add(0,1,1,0,0, 1,0,0, 3,2,7);
    add(0,0,0,0,0, 0,1,0, 3,5,7);
    add(1,0,0,0,0, 0,1,0, 3,5,7);
    add(0,0,0,0,0, 0,1,0, 3,5,7);
    add(0,0,0,0,1, 0,1,0, 3,5,7);
    add(0,0,0,0,0, 0,0,0, 3,5,7);
    // Fifteen zeros overflow MAX_LZ=14; a Start then recovers the parser for code "1".
    add(1,0,0,0,0, 0,0,0, 3,5,7);
    for (int k = 0; k < 15; k++) add(0,0,1,0,0, 1,0,0, 4'(k),0,0);
    add(0,0,1,0,1, 0,0,1, 14,0,0);
    add(1,0,0,0,0, 0,0,1, 14,0,0);
    add(0,1,1,0,1, 1,0,0, 0,0,0);
    add(0,0,0,0,1, 0,1,0, 0,0,1);
    add(0,0,0,0,0, 0,0,0, 0,0,1);

    rst_n_i = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    #12;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 5'd0);
`ifdef COEFF_TOKEN_BITCOUNT_EN
    chk("reset bit_count", bit_count_o, 16'h0000);
`endif
    rst_n_i = 1'b1;
    step();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].start, vecs[i].bin, vecs[i].bvld, vecs[i].slen, vecs[i].trdy);
      #1;
      chk_all($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_tv, vecs[i].e_err,
              vecs[i].e_lz, vecs[i].e_sfx, vecs[i].e_cl);
      step();
    end

    // Reset asserted during SUFFIX: outputs clear at once and no token appears afterwards.
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    step();
    chk("pre-reset code_len", 16'(code_len_o), 16'd3);
    chk("pre-reset suffix", 16'(suffix_o), 16'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk_all("async reset", 1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 5'd0);
    #2;
    rst_n_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("post-reset cyc%0d token_valid", k), 16'(token_valid_o), 16'd0);
      chk($sformatf("post-reset cyc%0d bit_ready", k), 16'(bit_ready_o), 16'd0);
    end

    // A Start held across reset release is honoured on the first rising edge.
    #2;
    rst_n_i = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    #3;
    rst_n_i = 1'b1;
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    chk("first-edge start bit_ready", 16'(bit_ready_o), 16'd1);
    chk("first-edge start error", 16'(error_o), 16'd0);

`ifdef COEFF_TOKEN_BITCOUNT_EN
    // The parser is in PREFIX and no bits have been taken since the reset.
    // 4368 overflow rounds of 15 zeros give 65520 accepted bits.
    for (int r = 0; r < 4368; r++) begin
      if (r != 0) begin
        drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        step();
      end
      feed_zeros(15);
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
    step();
    feed_zeros(13);
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step();
    chk("bit_count preload", bit_count_o, 16'hFFFE);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b1, 2'd1, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b1, 2'd0, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("bit_count wrap", bit_count_o, 16'h0000);
    chk("wrap token code_len", 16'(code_len_o), 16'd2);
    chk("wrap token suffix", 16'(suffix_o), 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
